// File: rtl/fetch_if.sv
//------------------------------------------------------------------------------
// fetch_if : control, instruction-memory and IF/ID signals of the fetch stage
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_if;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misalign_e;
  logic [31:0] fetch_count;

  modport master (
    input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
    output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, misalign_e, fetch_count
  );

  modport slave (
    output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
    input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, misalign_e, fetch_count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage : RV32I instruction fetch - PC register and IF/ID pipeline register
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013,
  parameter logic [31:0] CNT_INIT = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_plus4_f;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;
  logic        ifid_load;

  assign pc_plus4_f = pc_f_q + 32'd4;
  assign ifid_load  = !bus.flush_d && !bus.stall_d;

  // Redirect takes priority over stall_f so a taken branch is never lost.
  always_comb begin
    pc_f_d = pc_plus4_f;
    if (bus.pc_src_e) begin
      pc_f_d = {bus.pc_target_e[31:2], 2'b00};
    end else if (bus.stall_f) begin
      pc_f_d = pc_f_q;
    end
  end

  assign misalign_d = bus.pc_src_e && (bus.pc_target_e[1:0] != 2'b00);

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;
    if (bus.flush_d) begin
      ifid_instr_d = NOP;
      ifid_pc_d    = 32'd0;
      ifid_pc4_d   = 32'd0;
      ifid_valid_d = 1'b0;
    end else if (!bus.stall_d) begin
      ifid_instr_d = bus.imem_rdata;
      ifid_pc_d    = pc_f_q;
      ifid_pc4_d   = pc_plus4_f;
      ifid_valid_d = 1'b1;
    end
    if (ifid_load) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q       <= RESET_PC;
      ifid_instr_q <= NOP;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      count_q      <= CNT_INIT;
    end else begin
      pc_f_q       <= pc_f_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
      count_q      <= count_d;
    end
  end

  assign bus.imem_addr   = pc_f_q;
  assign bus.instr_d     = ifid_instr_q;
  assign bus.pc_d        = ifid_pc_q;
  assign bus.pc_plus4_d  = ifid_pc4_q;
  assign bus.valid_d     = ifid_valid_q;
  assign bus.misalign_e  = misalign_q;
  assign bus.fetch_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// tb_fetch_stage : directed vector bench for fetch_stage
// Revision       : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  typedef struct {
    logic        sf, sd, fl, src;
    logic [31:0] tgt;
    logic [31:0] addr, pcd, pc4, instr;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
  } vec_t;

  localparam int NV = 24;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t v [NV];

  fetch_if bus1 ();
  fetch_if bus2 ();

  fetch_stage dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_INIT(32'hFFFF_FFFE)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus1.imem_rdata = bus1.imem_addr ^ 32'hA5A5_0000;
  assign bus2.imem_rdata = bus2.imem_addr ^ 32'hA5A5_0000;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, ".addr"},  bus1.imem_addr, 32'h0);
    chk({tag, ".instr"}, bus1.instr_d, 32'h13);
    chk({tag, ".pcd"},   bus1.pc_d, 32'h0);
    chk({tag, ".pc4"},   bus1.pc_plus4_d, 32'h0);
    chk({tag, ".valid"}, {31'd0, bus1.valid_d}, 32'd0);
    chk({tag, ".mis"},   {31'd0, bus1.misalign_e}, 32'd0);
    chk({tag, ".cnt"},   bus1.fetch_count, 32'd0);
  endtask

  task automatic setv(input int i, input logic sf, input logic sd, input logic fl,
                      input logic src, input logic [31:0] tgt, input logic [31:0] addr,
                      input logic [31:0] pcd, input logic [31:0] pc4, input logic valid,
                      input logic [31:0] cnt, input logic mis);
    v[i].sf = sf; v[i].sd = sd; v[i].fl = fl; v[i].src = src; v[i].tgt = tgt;
    v[i].addr = addr; v[i].pcd = pcd; v[i].pc4 = pc4;
    v[i].instr = valid ? (pcd ^ 32'hA5A5_0000) : 32'h13;
    v[i].valid = valid; v[i].cnt = cnt; v[i].mis = mis;
  endtask

  initial begin
    // Sequential fetch up to pc_f=0x20
    setv( 0, 0,0,0,0, 32'h0,   32'h04,  32'h00,  32'h04,  1, 1,  0);
    setv( 1, 0,0,0,0, 32'h0,   32'h08,  32'h04,  32'h08,  1, 2,  0);
    setv( 2, 0,0,0,0, 32'h0,   32'h0C,  32'h08,  32'h0C,  1, 3,  0);
    setv( 3, 0,0,0,0, 32'h0,   32'h10,  32'h0C,  32'h10,  1, 4,  0);
    setv( 4, 0,0,0,0, 32'h0,   32'h14,  32'h10,  32'h14,  1, 5,  0);
    setv( 5, 0,0,0,0, 32'h0,   32'h18,  32'h14,  32'h18,  1, 6,  0);
    setv( 6, 0,0,0,0, 32'h0,   32'h1C,  32'h18,  32'h1C,  1, 7,  0);
    setv( 7, 0,0,0,0, 32'h0,   32'h20,  32'h1C,  32'h20,  1, 8,  0);
    // Load-use stall for two cycles, then release
    setv( 8, 1,1,0,0, 32'h0,   32'h20,  32'h1C,  32'h20,  1, 8,  0);
    setv( 9, 1,1,0,0, 32'h0,   32'h20,  32'h1C,  32'h20,  1, 8,  0);
    setv(10, 0,0,0,0, 32'h0,   32'h24,  32'h20,  32'h24,  1, 9,  0);
    // Redirect with flush, then target arrives
    setv(11, 0,0,1,1, 32'h40,  32'h40,  32'h0,   32'h0,   0, 9,  0);
    setv(12, 0,0,0,0, 32'h0,   32'h44,  32'h40,  32'h44,  1, 10, 0);
    // Redirect beats stall_f
    setv(13, 1,0,0,1, 32'h80,  32'h80,  32'h44,  32'h48,  1, 11, 0);
    setv(14, 0,0,0,0, 32'h0,   32'h84,  32'h80,  32'h84,  1, 12, 0);
    // Flush beats stall_d
    setv(15, 0,1,1,0, 32'h0,   32'h88,  32'h0,   32'h0,   0, 12, 0);
    setv(16, 0,0,0,0, 32'h0,   32'h8C,  32'h88,  32'h8C,  1, 13, 0);
    // Misaligned redirect pulses misalign_e for one cycle
    setv(17, 0,0,0,1, 32'h106, 32'h104, 32'h8C,  32'h90,  1, 14, 1);
    setv(18, 0,0,0,0, 32'h0,   32'h108, 32'h104, 32'h108, 1, 15, 0);
    // stall_f without stall_d reloads the same instruction
    setv(19, 1,0,0,0, 32'h0,   32'h108, 32'h108, 32'h10C, 1, 16, 0);
    setv(20, 1,0,0,0, 32'h0,   32'h108, 32'h108, 32'h10C, 1, 17, 0);
    setv(21, 0,0,0,0, 32'h0,   32'h10C, 32'h108, 32'h10C, 1, 18, 0);
    setv(22, 0,0,0,1, 32'h200, 32'h200, 32'h10C, 32'h110, 1, 19, 0);
    setv(23, 0,0,0,0, 32'h0,   32'h204, 32'h200, 32'h204, 1, 20, 0);

    rst = 1'b1;
    {bus1.stall_f, bus1.stall_d, bus1.flush_d, bus1.pc_src_e} = 4'b0;
    {bus2.stall_f, bus2.stall_d, bus2.flush_d, bus2.pc_src_e} = 4'b0;
    bus1.pc_target_e = 32'h0;
    bus2.pc_target_e = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset1("rst");
    chk("rst2.addr", bus2.imem_addr, 32'hFFFF_FFF8);
    chk("rst2.cnt",  bus2.fetch_count, 32'hFFFF_FFFE);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus1.stall_f     = v[i].sf;
      bus1.stall_d     = v[i].sd;
      bus1.flush_d     = v[i].fl;
      bus1.pc_src_e    = v[i].src;
      bus1.pc_target_e = v[i].tgt;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.addr", i),  bus1.imem_addr, v[i].addr);
      chk($sformatf("v%0d.pcd", i),   bus1.pc_d, v[i].pcd);
      chk($sformatf("v%0d.pc4", i),   bus1.pc_plus4_d, v[i].pc4);
      chk($sformatf("v%0d.instr", i), bus1.instr_d, v[i].instr);
      chk($sformatf("v%0d.valid", i), {31'd0, bus1.valid_d}, {31'd0, v[i].valid});
      chk($sformatf("v%0d.cnt", i),   bus1.fetch_count, v[i].cnt);
      chk($sformatf("v%0d.mis", i),   {31'd0, bus1.misalign_e}, {31'd0, v[i].mis});
      if (i == 0) begin
        chk("wrap.addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("wrap.pcd0",  bus2.pc_d, 32'hFFFF_FFF8);
        chk("wrap.cnt0",  bus2.fetch_count, 32'hFFFF_FFFF);
      end else if (i == 1) begin
        chk("wrap.addr1", bus2.imem_addr, 32'h0);
        chk("wrap.pcd1",  bus2.pc_d, 32'hFFFF_FFFC);
        chk("wrap.pc41",  bus2.pc_plus4_d, 32'h0);
        chk("wrap.cnt1",  bus2.fetch_count, 32'h0);
      end
    end

    // Asynchronous reset asserted mid-stall, away from any clock edge
    bus1.stall_f = 1'b1;
    bus1.stall_d = 1'b1;
    bus1.pc_src_e = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset1("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    {bus1.stall_f, bus1.stall_d, bus1.flush_d, bus1.pc_src_e} = 4'b0;
    @(posedge clk);
    #1;
    chk("post.addr",  bus1.imem_addr, 32'h4);
    chk("post.pcd",   bus1.pc_d, 32'h0);
    chk("post.instr", bus1.instr_d, 32'hA5A5_0000);
    chk("post.valid", {31'd0, bus1.valid_d}, 32'd1);
    chk("post.cnt",   bus1.fetch_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
